falling_object_spawner: RTL

FALLING_OBJECT_SPAWNER -- requirements
Module: falling_object_spawner

---
 rtl/falling_pkg.sv | 15 +
 rtl/lfsr16.sv | 20 ++
 rtl/falling_object_spawner.sv | 100 ++++++++++
 3 files changed

// File: rtl/falling_pkg.sv
// Shared types and constants for the falling object spawner.
// Holds the spawner state enum and screen-level constants.
package falling_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD,
    FALL
  } state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int SCREEN_WIDTH           = 640;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Free-running; reloads the seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic w_fb;

  assign w_fb = out[15] ^ out[13] ^ out[12] ^ out[10];

  // Shift one position every clock.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) out <= seed;
    else         out <= {out[14:0], w_fb};
  end

endmodule

// File: rtl/falling_object_spawner.sv
// Spawner: waits a frame delay, pulses load, then keeps the
// object visible until it leaves the screen or hits the player.
module falling_object_spawner
  import falling_pkg::*;
#(
  parameter int          SPAWN_DELAY_FRAMES = 60,
  parameter int          MIN_X              = 32,
  parameter int          MAX_X              = 576,
  parameter int          BASE_SPEED         = 128,
  parameter int          SPEED_STEP         = 16,
  parameter int          MAX_SPEED          = 512,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               exceed,
  input  logic               collision,
  output logic               load,
  output logic               visible,
  output int                 speed,
  output logic signed [10:0] topLeftXRand,
  output logic [7:0]         spawnCount
);

  localparam int          RANGE      = MAX_X - MIN_X + 1;
  localparam logic [15:0] LAST_FRAME = 16'(SPAWN_DELAY_FRAMES - 1);

  state_t      r_state;
  logic [15:0] r_frames;
  logic [15:0] w_lfsr;
  logic [31:0] w_off;
  logic [10:0] w_spawn_x;
  int          w_speed_up;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .seed   (LFSR_SEED),
    .out    (w_lfsr)
  );

  assign w_off      = {22'd0, w_lfsr[9:0]} % 32'(RANGE);
  assign w_spawn_x  = 11'(32'(MIN_X) + w_off);
  assign w_speed_up = (speed + SPEED_STEP > MAX_SPEED) ?
                      MAX_SPEED : speed + SPEED_STEP;

  // Spawn FSM with registered outputs; enable low wins everywhere.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_frames     <= '0;
      load         <= 1'b0;
      visible      <= 1'b0;
      speed        <= BASE_SPEED;
      topLeftXRand <= 11'(MIN_X);
      spawnCount   <= '0;
    end else if (!enable) begin
      r_state <= IDLE;
      load    <= 1'b0;
      visible <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state  <= WAIT;
          r_frames <= '0;
        end
        WAIT: begin
          if (startOfFrame) begin
            if (r_frames == LAST_FRAME) begin
              r_state      <= LOAD;
              load         <= 1'b1;
              topLeftXRand <= w_spawn_x;
              if (spawnCount != 8'hFF)
                spawnCount <= spawnCount + 8'd1;
            end else begin
              r_frames <= r_frames + 16'd1;
            end
          end
        end
        LOAD: begin
          r_state <= FALL;
          load    <= 1'b0;
          visible <= 1'b1;
        end
        FALL: begin
          if (exceed || collision) begin
            r_state  <= WAIT;
            visible  <= 1'b0;
            r_frames <= '0;
            if (collision) speed <= w_speed_up;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
